// File: rtl/jtopl_slot_wr.sv
// rtl/jtopl_slot_wr.sv - slot counter and single-entry write merge ahead of the operator ring
// Holds one pending slot write and splices it into the ring feedback path when the ring reaches the target slot.
module jtopl_slot_wr #(
  parameter int WIDTH = 8,
  parameter int SLOTS = 18,
  parameter int SLOTW = 5
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_cen,
  input  logic             i_wr_en,
  input  logic [SLOTW-1:0] i_wr_slot,
  input  logic [WIDTH-1:0] i_wr_data,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_ovf,
  input  logic [WIDTH-1:0] i_fb_in,
  output logic [WIDTH-1:0] o_ring_out,
  output logic [SLOTW-1:0] o_slot,
  output logic             o_zero
);

  localparam logic [SLOTW:0]   LP_SLOTS = (SLOTW+1)'(SLOTS);
  localparam logic [SLOTW-1:0] LP_LAST  = SLOTW'(SLOTS - 1);

  logic [SLOTW-1:0] r_slot;
  logic [SLOTW-1:0] r_pend_slot;
  logic [WIDTH-1:0] r_pend_data;
  logic             r_busy;
  logic             r_done;
  logic             r_ovf;

  logic             w_match;
  logic             w_commit;
  logic             w_slot_ok;

  // Match uses registered pending state only, so a same-edge accept cannot commit.
  assign w_match   = r_busy && (r_pend_slot == r_slot);
  assign w_commit  = i_cen && w_match;
  assign w_slot_ok = ({1'b0, i_wr_slot} < LP_SLOTS);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_slot      <= '0;
      r_pend_slot <= '0;
      r_pend_data <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_ovf       <= 1'b0;
    end else begin
      r_done <= w_commit;
      if (i_cen) begin
        r_slot <= (r_slot == LP_LAST) ? '0 : r_slot + SLOTW'(1);
      end
      if (i_wr_en) begin
        if (r_busy) begin
          r_ovf <= 1'b1;
        end else if (w_slot_ok) begin
          r_pend_slot <= i_wr_slot;
          r_pend_data <= i_wr_data;
          r_busy      <= 1'b1;
        end
      end
      // Commit only happens while busy, which also rejects any same-cycle request.
      if (w_commit) begin
        r_busy <= 1'b0;
      end
    end
  end

  assign o_ring_out = w_match ? r_pend_data : i_fb_in;
  assign o_slot     = r_slot;
  assign o_zero     = (r_slot == '0);
  assign o_busy     = r_busy;
  assign o_done     = r_done;
  assign o_ovf      = r_ovf;

endmodule

// File: tb/tb_jtopl_slot_wr.sv
// tb/tb_jtopl_slot_wr.sv - bench for jtopl_slot_wr with a modelled 18-deep ring
// The ring is a shift register fed by the DUT; the model tracks per-slot contents by slot number.
module tb_jtopl_slot_wr;

  localparam int W  = 8;
  localparam int N  = 18;
  localparam int SW = 5;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cen = 1'b0;
  logic          wr_en = 1'b0;
  logic [SW-1:0] wr_slot = '0;
  logic [W-1:0]  wr_data = '0;
  logic          busy, done, ovf, zero;
  logic [W-1:0]  ring_out;
  logic [W-1:0]  fb_in;
  logic [SW-1:0] slot;
  logic [W-1:0]  sr [N];

  assign fb_in = sr[N-1];

  always #5 clk = ~clk;

  jtopl_slot_wr #(.WIDTH(W), .SLOTS(N), .SLOTW(SW)) dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_cen      (cen),
    .i_wr_en    (wr_en),
    .i_wr_slot  (wr_slot),
    .i_wr_data  (wr_data),
    .o_busy     (busy),
    .o_done     (done),
    .o_ovf      (ovf),
    .i_fb_in    (fb_in),
    .o_ring_out (ring_out),
    .o_slot     (slot),
    .o_zero     (zero)
  );

  int          checks = 0;
  int          errors = 0;
  int          m_slot;
  int          m_pslot;
  bit          m_busy;
  bit          m_ovf;
  bit          m_done;
  logic [W-1:0] m_pdata;
  logic [W-1:0] m_mem [N];
  bit          last_done;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Fresh random ring contents; slot s appears on fb_in when the counter reads s.
  task automatic load_ring();
    for (int s = 0; s < N; s++) begin
      m_mem[s]   = W'($urandom);
      sr[N-1-s]  = m_mem[s];
    end
  endtask

  task automatic step(input bit c, input bit w, input int ws, input logic [W-1:0] wd);
    logic [W-1:0] ro_exp;
    logic [W-1:0] ro;
    bit           commit;
    @(negedge clk);
    cen = c; wr_en = w; wr_slot = SW'(ws); wr_data = wd;
    #1;
    ro_exp = (m_busy && m_pslot == m_slot) ? m_pdata : m_mem[m_slot];
    chk("slot", 32'(slot), 32'(m_slot));
    chk("zero", 32'(zero), 32'(m_slot == 0));
    chk("busy", 32'(busy), 32'(m_busy));
    chk("ovf", 32'(ovf), 32'(m_ovf));
    chk("fb_in", 32'(fb_in), 32'(m_mem[m_slot]));
    chk("ring_out", 32'(ring_out), 32'(ro_exp));
    ro = ring_out;
    commit = c && m_busy && (m_pslot == m_slot);
    if (c) m_mem[m_slot] = ro_exp;
    m_done = commit;
    if (w) begin
      if (m_busy) m_ovf = 1'b1;
      else if (ws < N) begin
        m_busy  = 1'b1;
        m_pslot = ws;
        m_pdata = wd;
      end
    end
    if (commit) m_busy = 1'b0;
    if (c) m_slot = (m_slot + 1) % N;
    @(posedge clk);
    #1;
    if (c) begin
      for (int i = N-1; i > 0; i--) sr[i] = sr[i-1];
      sr[0] = ro;
    end
    last_done = done;
    chk("done", 32'(done), 32'(m_done));
    chk("busy_post", 32'(busy), 32'(m_busy));
    chk("slot_post", 32'(slot), 32'(m_slot));
    chk("ovf_post", 32'(ovf), 32'(m_ovf));
    wr_en = 1'b0;
  endtask

  task automatic goto_slot(input int s);
    int g = 0;
    while (m_slot != s && g < 2*N) begin
      step(1'b1, 1'b0, 0, '0);
      g++;
    end
    chk("goto_slot", 32'(slot), 32'(s));
  endtask

  task automatic run_until_done(input string tag, input int exp_n);
    int n = 0;
    last_done = 1'b0;
    while (!last_done && n < 3*N) begin
      step(1'b1, 1'b0, 0, '0);
      n++;
    end
    chk(tag, 32'(n), 32'(exp_n));
  endtask

  task automatic do_reset();
    @(negedge clk);
    cen = 1'b0; wr_en = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_ovf", 32'(ovf), 32'd0);
    chk("rst_slot", 32'(slot), 32'd0);
    chk("rst_zero", 32'(zero), 32'd1);
    load_ring();
    #1;
    chk("rst_ring_out", 32'(ring_out), 32'(m_mem[0]));
    m_slot = 0; m_busy = 1'b0; m_ovf = 1'b0; m_done = 1'b0;
    m_pslot = 0; m_pdata = '0;
    @(posedge clk);
    #1;
    chk("rst_slot_hold", 32'(slot), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    load_ring();
    do_reset();

    // free-running revolutions
    repeat (40) step(1'b1, 1'b0, 0, '0);

    // write ahead of the slot: commit 3 pulses after accept
    goto_slot(2);
    step(1'b1, 1'b1, 5, 8'hA5);
    run_until_done("lat_slot5_from2", 3);

    // write at the target slot itself: full revolution
    goto_slot(5);
    step(1'b1, 1'b1, 5, 8'h3C);
    run_until_done("lat_slot5_from5", 18);

    // out-of-range slot is dropped silently
    step(1'b1, 1'b1, 20, 8'h77);
    repeat (3) step(1'b1, 1'b0, 0, '0);

    // request while busy is dropped and ovf sticks
    goto_slot(3);
    step(1'b1, 1'b1, 9, 8'h11);
    step(1'b1, 1'b1, 7, 8'hFF);
    run_until_done("lat_slot9", 5);
    repeat (20) step(1'b1, 1'b0, 0, '0);

    // request in the commit cycle is rejected
    goto_slot(12);
    step(1'b1, 1'b1, 14, 8'h42);
    step(1'b1, 1'b0, 0, '0);
    step(1'b1, 1'b1, 2, 8'h99);
    step(1'b1, 1'b0, 0, '0);

    // cen held low while sitting on the target slot: merged but not captured
    do_reset();
    goto_slot(9);
    step(1'b1, 1'b1, 10, 8'hC3);
    repeat (5) step(1'b0, 1'b0, 0, '0);
    step(1'b1, 1'b0, 0, '0);
    repeat (20) step(1'b1, 1'b0, 0, '0);

    // long stall then async reset discards the pending write
    goto_slot(4);
    step(1'b0, 1'b1, 10, 8'h5A);
    repeat (50) step(1'b0, 1'b0, 0, '0);
    do_reset();
    repeat (4) step(1'b1, 1'b0, 0, '0);

    // randomized traffic
    do_reset();
    repeat (400) begin
      step($urandom_range(0, 9) < 7, $urandom_range(0, 9) < 2,
           int'($urandom_range(0, 23)), W'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
